alu_issue_queue: RTL and testbench

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/alu_issue_queue.sv | 194 +++++++++++++++++++
 tb/tb_alu_issue_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// ALU issue queue: an age-ordered reservation station for ALU instructions.
// Entries are packed from index 0 (oldest) upward. Each cycle the lowest-index
// entry whose operands are both available is offered to the ALU, and the
// common data bus (CDB) wakes up waiting operands.
//
// Optional feature: define ALU_QUEUE_WAKEUP_BYPASS_EN so that an operand whose
// tag is on the CDB this cycle counts as ready, with cdb_data forwarded to
// issue_op1/issue_op2. Without the macro an entry woken by the CDB becomes
// issuable in the following cycle.
module alu_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        dispatch_en,
    input  logic [31:0] op1_data,
    input  logic [31:0] op2_data,
    input  logic [5:0]  op1_tag,
    input  logic [5:0]  op2_tag,
    input  logic        op1_valid,
    input  logic        op2_valid,
    input  logic [5:0]  rd_tag,
    input  logic [2:0]  funct3,
    input  logic [2:0]  alu_ext,
    output logic        queue_full,
    input  logic        cdb_valid,
    input  logic [5:0]  cdb_tag,
    input  logic [31:0] cdb_data,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [31:0] issue_op1,
    output logic [31:0] issue_op2,
    output logic [5:0]  issue_rd_tag,
    output logic [2:0]  issue_funct3,
    output logic [2:0]  issue_alu_ext
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

`ifdef ALU_QUEUE_WAKEUP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic        op1_v;
        logic        op2_v;
        logic [31:0] op1_d;
        logic [31:0] op2_d;
        logic [5:0]  op1_t;
        logic [5:0]  op2_t;
        logic [5:0]  rd;
        logic [2:0]  f3;
        logic [2:0]  ext;
    } entry_t;

    entry_t        ent [DEPTH];
    entry_t        nxt [DEPTH];
    logic [CW-1:0] count;
    logic [CW-1:0] cnt_after;
    logic [CW-1:0] nxt_count;
    logic [DEPTH-1:0] ready;
    logic [IW-1:0] sel;
    logic          found;
    logic          fire;
    logic          do_disp;
    entry_t        new_ent;

    // Latch CDB data into every still-waiting operand whose tag matches.
    function automatic entry_t capture(entry_t e, logic cv, logic [5:0] ct,
                                       logic [31:0] cd);
        entry_t r;
        r = e;
        if (cv && !e.op1_v && (e.op1_t == ct)) begin
            r.op1_v = 1'b1;
            r.op1_d = cd;
        end
        if (cv && !e.op2_v && (e.op2_t == ct)) begin
            r.op2_v = 1'b1;
            r.op2_d = cd;
        end
        return r;
    endfunction

    // Operand readiness; the bypass path also accepts a live CDB tag match.
    function automatic logic opnd_ready(logic v, logic [5:0] t, logic cv,
                                        logic [5:0] ct);
        return v || (BYPASS && cv && (t == ct));
    endfunction

    // Operand value seen by the ALU, forwarding the CDB when bypassing.
    function automatic logic [31:0] opnd_value(logic v, logic [5:0] t,
                                               logic [31:0] d, logic cv,
                                               logic [5:0] ct, logic [31:0] cd);
        if (!v && BYPASS && cv && (t == ct)) begin
            return cd;
        end
        return d;
    endfunction

    assign queue_full = (count == CW'(DEPTH));

    // Pick the oldest entry with both operands available.
    always_comb begin
        ready = '0;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = (CW'(i) < count)
                    && opnd_ready(ent[i].op1_v, ent[i].op1_t, cdb_valid, cdb_tag)
                    && opnd_ready(ent[i].op2_v, ent[i].op2_t, cdb_valid, cdb_tag);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel   = IW'(i);
                found = 1'b1;
            end
        end
    end

    // Drive the ALU-facing outputs; data is zero when nothing is offered.
    always_comb begin
        issue_valid   = found;
        issue_op1     = '0;
        issue_op2     = '0;
        issue_rd_tag  = '0;
        issue_funct3  = '0;
        issue_alu_ext = '0;
        if (found) begin
            issue_op1     = opnd_value(ent[sel].op1_v, ent[sel].op1_t, ent[sel].op1_d,
                                       cdb_valid, cdb_tag, cdb_data);
            issue_op2     = opnd_value(ent[sel].op2_v, ent[sel].op2_t, ent[sel].op2_d,
                                       cdb_valid, cdb_tag, cdb_data);
            issue_rd_tag  = ent[sel].rd;
            issue_funct3  = ent[sel].f3;
            issue_alu_ext = ent[sel].ext;
        end
    end

    // Next-state entries: remove the issued one, compact, wake up, append.
    always_comb begin
        fire      = issue_valid && issue_ready;
        do_disp   = dispatch_en && !queue_full;
        cnt_after = count - CW'(fire);
        nxt_count = cnt_after + CW'(do_disp);

        new_ent.op1_v = op1_valid;
        new_ent.op2_v = op2_valid;
        new_ent.op1_d = op1_data;
        new_ent.op2_d = op2_data;
        new_ent.op1_t = op1_tag;
        new_ent.op2_t = op2_tag;
        new_ent.rd    = rd_tag;
        new_ent.f3    = funct3;
        new_ent.ext   = alu_ext;
        new_ent       = capture(new_ent, cdb_valid, cdb_tag, cdb_data);

        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = '0;
            if (fire && (CW'(i) >= CW'(sel))) begin
                if (i + 1 < DEPTH) begin
                    nxt[i] = capture(ent[(i + 1 < DEPTH) ? i + 1 : i],
                                     cdb_valid, cdb_tag, cdb_data);
                end
            end else begin
                nxt[i] = capture(ent[i], cdb_valid, cdb_tag, cdb_data);
            end
            if (do_disp && (CW'(i) == cnt_after)) begin
                nxt[i] = new_ent;
            end
        end
    end

    // Register entries and occupancy; flush empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= nxt_count;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue (DEPTH=4). Expected issue
// transactions are queued as stimulus is applied; a monitor compares every
// accepted issue against the head of that queue.
module tb_alu_issue_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        dispatch_en;
    logic [31:0] op1_data, op2_data;
    logic [5:0]  op1_tag, op2_tag;
    logic        op1_valid, op2_valid;
    logic [5:0]  rd_tag;
    logic [2:0]  funct3, alu_ext;
    logic        queue_full;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_op1, issue_op2;
    logic [5:0]  issue_rd_tag;
    logic [2:0]  issue_funct3, issue_alu_ext;

    int errors = 0;
    int checks = 0;
    logic [75:0] exp_q[$];
    logic [75:0] head;

    alu_issue_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .dispatch_en(dispatch_en),
        .op1_data(op1_data), .op2_data(op2_data),
        .op1_tag(op1_tag), .op2_tag(op2_tag),
        .op1_valid(op1_valid), .op2_valid(op2_valid),
        .rd_tag(rd_tag), .funct3(funct3), .alu_ext(alu_ext),
        .queue_full(queue_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op1(issue_op1), .issue_op2(issue_op2),
        .issue_rd_tag(issue_rd_tag), .issue_funct3(issue_funct3),
        .issue_alu_ext(issue_alu_ext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every accepted issue must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got op1=%h op2=%h rd=%0d, required no issue",
                         issue_op1, issue_op2, issue_rd_tag);
            end else begin
                head = exp_q.pop_front();
                check("issue_txn",
                      {issue_op1, issue_op2, issue_rd_tag, issue_funct3, issue_alu_ext}, head);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d1, input logic v1, input logic [5:0] t1,
                         input logic [31:0] d2, input logic v2, input logic [5:0] t2,
                         input logic [5:0] rd, input logic [2:0] f3, input logic [2:0] ext);
        dispatch_en = 1'b1;
        op1_data = d1; op1_valid = v1; op1_tag = t1;
        op2_data = d2; op2_valid = v2; op2_tag = t2;
        rd_tag = rd; funct3 = f3; alu_ext = ext;
    endtask

    task automatic expect_issue(input logic [31:0] d1, input logic [31:0] d2,
                                input logic [5:0] rd, input logic [2:0] f3, input logic [2:0] ext);
        exp_q.push_back({d1, d2, rd, f3, ext});
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("drain_done", 76'(exp_q.size()), 76'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; dispatch_en = 1'b0;
        op1_data = '0; op2_data = '0; op1_tag = '0; op2_tag = '0;
        op1_valid = 1'b0; op2_valid = 1'b0; rd_tag = '0; funct3 = '0; alu_ext = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_full", 76'(queue_full), 76'd0);
        check("rst_issue_valid", 76'(issue_valid), 76'd0);
        check("rst_issue_data", {issue_op1, issue_op2, issue_rd_tag, issue_funct3, issue_alu_ext}, 76'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_issue_valid", 76'(issue_valid), 76'd0);
        check("post_rst_full", 76'(queue_full), 76'd0);

        // Simple dispatch and issue
        step();
        issue_ready = 1'b1;
        drive(32'd5, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 6'd1, 3'd0, 3'd0);
        expect_issue(32'd5, 32'd7, 6'd1, 3'd0, 3'd0);
        step();
        dispatch_en = 1'b0;
        @(negedge clk);
        check("t1_issue_valid", 76'(issue_valid), 76'd1);
        step();
        @(negedge clk);
        check("t1_empty_valid", 76'(issue_valid), 76'd0);
        check("t1_empty_full", 76'(queue_full), 76'd0);

        // Younger ready entry issues past an older waiting one
        step();
        drive(32'd0, 1'b0, 6'd3, 32'd1, 1'b1, 6'd0, 6'd2, 3'd1, 3'd0);
        step();
        drive(32'h10, 1'b1, 6'd0, 32'h20, 1'b1, 6'd0, 6'd3, 3'd2, 3'd1);
        expect_issue(32'h10, 32'h20, 6'd3, 3'd2, 3'd1);
        expect_issue(32'h99, 32'd1, 6'd2, 3'd1, 3'd0);
        @(negedge clk);
        check("t2_a_waits", 76'(issue_valid), 76'd0);
        step();
        dispatch_en = 1'b0;
        step();
        cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h99;
        step();
        cdb_valid = 1'b0;
        wait_drain();

        // Fill to capacity; full queue drops dispatches
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(32'h100 + 32'(k), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 6'(k + 4), 3'(k), 3'd2);
            expect_issue(32'h100 + 32'(k), 32'(k), 6'(k + 4), 3'(k), 3'd2);
            step();
        end
        dispatch_en = 1'b0;
        @(negedge clk);
        check("t3_full", 76'(queue_full), 76'd1);
        step();
        drive(32'hDEAD, 1'b1, 6'd0, 32'hDEAD, 1'b1, 6'd0, 6'd40, 3'd7, 3'd7);
        @(negedge clk);
        check("t3_hold_op1", 76'(issue_op1), 76'h100);
        step();
        issue_ready = 1'b1;
        drive(32'hBAD, 1'b1, 6'd0, 32'hBAD, 1'b1, 6'd0, 6'd41, 3'd7, 3'd7);
        @(negedge clk);
        check("t3_still_full", 76'(queue_full), 76'd1);
        step();
        issue_ready = 1'b0;
        dispatch_en = 1'b0;
        @(negedge clk);
        check("t3_one_free", 76'(queue_full), 76'd0);
        step();
        drive(32'h200, 1'b1, 6'd0, 32'h201, 1'b1, 6'd0, 6'd9, 3'd3, 3'd4);
        expect_issue(32'h200, 32'h201, 6'd9, 3'd3, 3'd4);
        step();
        dispatch_en = 1'b0;
        @(negedge clk);
        check("t3_refull", 76'(queue_full), 76'd1);
        step();
        issue_ready = 1'b1;
        wait_drain();

        // Wakeup of an operand being dispatched in the same cycle
        step();
        drive(32'h11, 1'b1, 6'd0, 32'd0, 1'b0, 6'd9, 6'd12, 3'd5, 3'd1);
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h1234;
        expect_issue(32'h11, 32'h1234, 6'd12, 3'd5, 3'd1);
        step();
        dispatch_en = 1'b0;
        cdb_valid = 1'b0;
        @(negedge clk);
        check("t4_ready_next", 76'(issue_valid), 76'd1);
        wait_drain();

        // Flush wins over a same-cycle dispatch
        issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(32'(k), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 6'(k), 3'd0, 3'd0);
            step();
        end
        flush = 1'b1;
        drive(32'h77, 1'b1, 6'd0, 32'h77, 1'b1, 6'd0, 6'd7, 3'd0, 3'd0);
        step();
        flush = 1'b0;
        dispatch_en = 1'b0;
        @(negedge clk);
        check("t5_issue_valid", 76'(issue_valid), 76'd0);
        check("t5_full", 76'(queue_full), 76'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(32'(k), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 6'(k), 3'd0, 3'd0);
            step();
        end
        dispatch_en = 1'b0;
        @(negedge clk);
        check("t5_count3_not_full", 76'(queue_full), 76'd0);
        step();
        drive(32'd3, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 6'd3, 3'd0, 3'd0);
        step();
        dispatch_en = 1'b0;
        @(negedge clk);
        check("t5_count4_full", 76'(queue_full), 76'd1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;

        // CDB wakeup latency of a waiting entry
        issue_ready = 1'b1;
        drive(32'd0, 1'b0, 6'd12, 32'd5, 1'b1, 6'd0, 6'd20, 3'd6, 3'd3);
        expect_issue(32'hABCD, 32'd5, 6'd20, 3'd6, 3'd3);
        step();
        dispatch_en = 1'b0;
        @(negedge clk);
        check("t6_waiting", 76'(issue_valid), 76'd0);
        step();
        cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'hABCD;
        @(negedge clk);
`ifdef ALU_QUEUE_WAKEUP_BYPASS_EN
        check("t6_same_cycle", 76'(issue_valid), 76'd1);
`else
        check("t6_same_cycle", 76'(issue_valid), 76'd0);
`endif
        step();
        cdb_valid = 1'b0;
        @(negedge clk);
`ifdef ALU_QUEUE_WAKEUP_BYPASS_EN
        check("t6_next_cycle", 76'(issue_valid), 76'd0);
`else
        check("t6_next_cycle", 76'(issue_valid), 76'd1);
`endif
        wait_drain();

        // Asynchronous reset with an entry pending
        issue_ready = 1'b0;
        drive(32'h55, 1'b1, 6'd0, 32'h66, 1'b1, 6'd0, 6'd30, 3'd1, 3'd1);
        step();
        dispatch_en = 1'b0;
        @(negedge clk);
        check("t7_pending", 76'(issue_valid), 76'd1);
        #1;
        rst = 1'b0;
        #1;
        check("t7_rst_valid", 76'(issue_valid), 76'd0);
        check("t7_rst_op1", 76'(issue_op1), 76'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("t7_after_rst", 76'(issue_valid), 76'd0);

        check("scoreboard_empty", 76'(exp_q.size()), 76'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
